// File: rtl/savestate_pkg.sv
// Shared types and result codes for the savestate sequencer.
package savestate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_START,
        ST_RUN,
        ST_RELEASE
    } state_t;

    typedef enum logic {
        OP_SAVE = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

    localparam logic [7:0] INFO_SAVE_BASE = 8'd16;
    localparam logic [7:0] INFO_LOAD_BASE = 8'd20;
    localparam logic [7:0] INFO_EMPTY     = 8'd24;
    localparam logic [7:0] INFO_TIMEOUT   = 8'd25;

    // Completion code reported to the OSD: base for the direction plus slot number.
    function automatic logic [7:0] done_code(input op_t op, input logic [1:0] slot);
        return ((op == OP_SAVE) ? INFO_SAVE_BASE : INFO_LOAD_BASE) + {6'b0, slot};
    endfunction

endpackage

// File: rtl/savestate_pending.sv
// One-entry request buffer: a new write overwrites the held entry, take clears it.
module savestate_pending
    import savestate_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_wr,
    input  op_t        i_op,
    input  logic [1:0] i_slot,
    input  logic       i_take,
    output logic       o_valid,
    output op_t        o_op,
    output logic [1:0] o_slot
);

    logic       r_valid;
    op_t        r_op;
    logic [1:0] r_slot;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_op    <= OP_SAVE;
            r_slot  <= 2'd0;
        end else if (i_wr) begin
            // A write in the same cycle as a take is a newer request and must survive.
            r_valid <= 1'b1;
            r_op    <= i_op;
            r_slot  <= i_slot;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_slot  = r_slot;

endmodule

// File: rtl/savestate_sequencer.sv
// Savestate sequencer: pauses the core, runs the savestate engine on a slot, releases the core.
// Define SS_SLOT_VALID_EN to enable slot-valid tracking and empty-slot load rejection.
module savestate_sequencer
    import savestate_pkg::*;
#(
    parameter int                ADDR_W         = 25,
    parameter int                SLOT_SIZE_LOG2 = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                TIMEOUT_BITS   = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ss_save,
    input  logic              ss_load,
    input  logic [1:0]        selected_slot,
    input  logic              slots_invalidate,
    input  logic              pause_ack,
    input  logic              engine_done,
    output logic              pause_req,
    output logic              ss_start_save,
    output logic              ss_start_load,
    output logic [ADDR_W-1:0] ss_addr,
    output logic              busy,
    output logic [3:0]        slot_valid,
    output logic              info_req,
    output logic [7:0]        info
);

    state_t                  r_state, w_state_next;
    op_t                     r_op;
    logic [1:0]              r_slot;
    logic [ADDR_W-1:0]       r_addr;
    logic [TIMEOUT_BITS-1:0] r_cnt, w_cnt_inc;
    logic                    r_info_req;
    logic [7:0]              r_info;

    logic       w_pend_valid, w_pend_wr, w_pend_take;
    op_t        w_pend_op;
    logic [1:0] w_pend_slot;
    logic       w_live_valid;
    op_t        w_live_op;
    logic       w_sel_valid, w_sel_empty;
    op_t        w_sel_op;
    logic [1:0] w_sel_slot;
    logic       w_latch, w_reject, w_timeout, w_done;

    // Save beats load when both pulse together.
    assign w_live_valid = ss_save | ss_load;
    assign w_live_op    = ss_save ? OP_SAVE : OP_LOAD;

    // IDLE consumes the buffered entry first; a live pulse is buffered unless IDLE takes it directly.
    assign w_pend_take = (r_state == ST_IDLE) && w_pend_valid;
    assign w_pend_wr   = w_live_valid && !((r_state == ST_IDLE) && !w_pend_valid);
    assign w_sel_valid = w_pend_valid | w_live_valid;
    assign w_sel_op    = w_pend_valid ? w_pend_op   : w_live_op;
    assign w_sel_slot  = w_pend_valid ? w_pend_slot : selected_slot;
    assign w_cnt_inc   = r_cnt + TIMEOUT_BITS'(1);

    savestate_pending u_pending (
        .clk     (clk),
        .reset_n (reset_n),
        .i_wr    (w_pend_wr),
        .i_op    (w_live_op),
        .i_slot  (selected_slot),
        .i_take  (w_pend_take),
        .o_valid (w_pend_valid),
        .o_op    (w_pend_op),
        .o_slot  (w_pend_slot)
    );

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_reject     = 1'b0;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    if (w_sel_empty) begin
                        w_reject = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_ack) begin
                    w_state_next = ST_START;
                end else if (w_cnt_inc[TIMEOUT_BITS-1]) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: w_state_next = ST_RUN;
            ST_RUN: begin
                if (engine_done) begin
                    w_done       = 1'b1;
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!pause_ack) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: every control flop is on the asynchronous reset so an abort mid-operation
    // drops pause_req and the start strobes immediately, without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_SAVE;
            r_slot     <= 2'd0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_info_req <= 1'b0;
            r_info     <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_info_req <= 1'b0;
            r_cnt      <= ((r_state == ST_PAUSE) && (w_state_next == ST_PAUSE)) ? w_cnt_inc : '0;
            if (w_latch) begin
                r_op   <= w_sel_op;
                r_slot <= w_sel_slot;
                r_addr <= BASE_ADDR + (ADDR_W'(w_sel_slot) << SLOT_SIZE_LOG2);
            end
            if (w_reject) begin
                r_info_req <= 1'b1;
                r_info     <= INFO_EMPTY;
            end
            if (w_timeout) begin
                r_info_req <= 1'b1;
                r_info     <= INFO_TIMEOUT;
            end
            if (w_done) begin
                r_info_req <= 1'b1;
                r_info     <= done_code(r_op, r_slot);
            end
        end
    end

`ifdef SS_SLOT_VALID_EN
    logic [3:0] r_slot_valid;

    // Invalidate has priority over a save completing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_valid <= 4'h0;
        end else if (slots_invalidate) begin
            r_slot_valid <= 4'h0;
        end else if (w_done && (r_op == OP_SAVE)) begin
            r_slot_valid[r_slot] <= 1'b1;
        end
    end

    assign slot_valid  = r_slot_valid;
    assign w_sel_empty = (w_sel_op == OP_LOAD) && !r_slot_valid[w_sel_slot];
`else
    logic w_unused_invalidate;

    assign w_unused_invalidate = slots_invalidate;
    assign slot_valid          = 4'hF;
    assign w_sel_empty         = 1'b0;
`endif

    assign pause_req     = (r_state == ST_PAUSE) || (r_state == ST_START) || (r_state == ST_RUN);
    assign ss_start_save = (r_state == ST_START) && (r_op == OP_SAVE);
    assign ss_start_load = (r_state == ST_START) && (r_op == OP_LOAD);
    assign ss_addr       = r_addr;
    assign busy          = (r_state != ST_IDLE);
    assign info_req      = r_info_req;
    assign info          = r_info;

endmodule

// File: tb/tb_savestate_sequencer.sv
// Self-checking bench for savestate_sequencer; expectations follow SS_SLOT_VALID_EN when defined.
module tb_savestate_sequencer;

    localparam int AW = 25;

`ifdef SS_SLOT_VALID_EN
    localparam logic [3:0] VALID_RST = 4'h0;
`else
    localparam logic [3:0] VALID_RST = 4'hF;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ss_save = 1'b0;
    logic          ss_load = 1'b0;
    logic [1:0]    selected_slot = 2'd0;
    logic          slots_invalidate = 1'b0;
    logic          pause_ack = 1'b0;
    logic          engine_done = 1'b0;
    logic          pause_req, ss_start_save, ss_start_load, busy, info_req;
    logic [AW-1:0] ss_addr;
    logic [3:0]    slot_valid;
    logic [7:0]    info;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic          load;
        logic [AW-1:0] addr;
    } start_t;

    start_t     q_start[$];
    logic [7:0] q_info[$];
    logic [3:0] m_valid = VALID_RST;
    start_t     mon_e;
    logic [7:0] mon_i;

    savestate_sequencer #(.TIMEOUT_BITS(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ss_save          (ss_save),
        .ss_load          (ss_load),
        .selected_slot    (selected_slot),
        .slots_invalidate (slots_invalidate),
        .pause_ack        (pause_ack),
        .engine_done      (engine_done),
        .pause_req        (pause_req),
        .ss_start_save    (ss_start_save),
        .ss_start_load    (ss_start_load),
        .ss_addr          (ss_addr),
        .busy             (busy),
        .slot_valid       (slot_valid),
        .info_req         (info_req),
        .info             (info)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] slot_addr(input logic [1:0] s);
        return AW'(s) << 22;
    endfunction

    // Scoreboard: every start strobe and info pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ss_start_save || ss_start_load) begin
                checks++;
                if (q_start.size() == 0) begin
                    failures++;
                    $display("FAIL start_unexpected got save=%0b load=%0b addr=%h, required no start",
                             ss_start_save, ss_start_load, ss_addr);
                end else begin
                    mon_e = q_start.pop_front();
                    if ({ss_start_load, ss_start_save, ss_addr} !== {mon_e.load, !mon_e.load, mon_e.addr}) begin
                        failures++;
                        $display("FAIL start_match got load=%0b save=%0b addr=%h, required load=%0b addr=%h",
                                 ss_start_load, ss_start_save, ss_addr, mon_e.load, mon_e.addr);
                    end
                end
            end
            if (info_req) begin
                checks++;
                if (q_info.size() == 0) begin
                    failures++;
                    $display("FAIL info_unexpected got info=%0d, required no info pulse", info);
                end else begin
                    mon_i = q_info.pop_front();
                    if (info !== mon_i) begin
                        failures++;
                        $display("FAIL info_match got %0d, required %0d", info, mon_i);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        ss_save = 1'b0;
        ss_load = 1'b0;
        pause_ack = 1'b0;
        engine_done = 1'b0;
        slots_invalidate = 1'b0;
        q_start.delete();
        q_info.delete();
        m_valid = VALID_RST;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic request(input logic sv, input logic ld, input logic [1:0] slot);
        ss_save = sv;
        ss_load = ld;
        selected_slot = slot;
        tick();
        ss_save = 1'b0;
        ss_load = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!(ss_start_save || ss_start_load) && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (!(ss_start_save || ss_start_load)) begin
            failures++;
            $display("FAIL %s_start_timeout got no start in %0d cycles, required a start", name, n);
        end
    endtask

    // Drives the core/engine handshake from PAUSE entry through RELEASE exit.
    task automatic serve(input logic ld, input logic [1:0] slot, input int ack_delay,
                         input int done_delay, input logic inv);
        repeat (ack_delay) tick();
        pause_ack = 1'b1;
        wait_start("serve");
        tick();
        repeat (done_delay - 1) tick();
        engine_done = 1'b1;
        slots_invalidate = inv;
        tick();
        engine_done = 1'b0;
        slots_invalidate = 1'b0;
`ifdef SS_SLOT_VALID_EN
        if (inv) m_valid = 4'h0;
        else if (!ld) m_valid[slot] = 1'b1;
`endif
        checks++;
        if (pause_req !== 1'b0) begin
            failures++;
            $display("FAIL serve_pause_drop got %0b, required 0", pause_req);
        end
        checks++;
        if (slot_valid !== m_valid) begin
            failures++;
            $display("FAIL serve_slot_valid got %b, required %b", slot_valid, m_valid);
        end
        pause_ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL serve_idle got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({pause_req, ss_start_save, ss_start_load, busy, info_req} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b, required 00000",
                     {pause_req, ss_start_save, ss_start_load, busy, info_req});
        end
        checks++;
        if ({ss_addr, info} !== {AW'(0), 8'd0}) begin
            failures++;
            $display("FAIL reset_data got addr=%h info=%0d, required 0 0", ss_addr, info);
        end
        checks++;
        if (slot_valid !== VALID_RST) begin
            failures++;
            $display("FAIL reset_slot_valid got %b, required %b", slot_valid, VALID_RST);
        end
        apply_reset();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_busy got %0b, required 0", busy);
        end
    endtask

    task automatic test_empty_load();
        apply_reset();
`ifdef SS_SLOT_VALID_EN
        q_info.push_back(8'd24);
        request(1'b0, 1'b1, 2'd1);
        checks++;
        if ({info_req, info, pause_req, busy} !== {1'b1, 8'd24, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL empty_reject got req=%0b info=%0d pause=%0b busy=%0b, required 1 24 0 0",
                     info_req, info, pause_req, busy);
        end
        tick();
        checks++;
        if (pause_req !== 1'b0) begin
            failures++;
            $display("FAIL empty_no_pause got %0b, required 0", pause_req);
        end
`else
        q_start.push_back('{load: 1'b1, addr: slot_addr(2'd1)});
        q_info.push_back(8'd21);
        request(1'b0, 1'b1, 2'd1);
        checks++;
        if ({pause_req, busy} !== 2'b11) begin
            failures++;
            $display("FAIL load_proceeds got pause=%0b busy=%0b, required 1 1", pause_req, busy);
        end
        serve(1'b1, 2'd1, 2, 4, 1'b0);
`endif
    endtask

    task automatic test_save_basic();
        q_start.push_back('{load: 1'b0, addr: 25'h0800000});
        q_info.push_back(8'd18);
        request(1'b1, 1'b0, 2'd2);
        checks++;
        if ({pause_req, busy} !== 2'b11) begin
            failures++;
            $display("FAIL save_pause got pause=%0b busy=%0b, required 1 1", pause_req, busy);
        end
        repeat (2) tick();
        pause_ack = 1'b1;
        tick();
        checks++;
        if ({ss_start_save, ss_start_load, ss_addr} !== {1'b1, 1'b0, 25'h0800000}) begin
            failures++;
            $display("FAIL save_start got save=%0b load=%0b addr=%h, required 1 0 0800000",
                     ss_start_save, ss_start_load, ss_addr);
        end
        tick();
        checks++;
        if ({ss_start_save, pause_req, busy} !== 3'b011) begin
            failures++;
            $display("FAIL save_run got start=%0b pause=%0b busy=%0b, required 0 1 1",
                     ss_start_save, pause_req, busy);
        end
        repeat (9) tick();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
`ifdef SS_SLOT_VALID_EN
        m_valid[2] = 1'b1;
`endif
        checks++;
        if ({info_req, info, pause_req, ss_addr, slot_valid} !== {1'b1, 8'd18, 1'b0, 25'h0800000, m_valid}) begin
            failures++;
            $display("FAIL save_done got req=%0b info=%0d pause=%0b addr=%h valid=%b, required 1 18 0 0800000 %b",
                     info_req, info, pause_req, ss_addr, slot_valid, m_valid);
        end
        tick();
        checks++;
        if ({info_req, busy} !== 2'b01) begin
            failures++;
            $display("FAIL save_release_wait got req=%0b busy=%0b, required 0 1", info_req, busy);
        end
        pause_ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL save_idle got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        q_info.push_back(8'd25);
        request(1'b1, 1'b0, 2'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!info_req && n < 20);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL timeout_latency got %0d cycles, required 8", n);
        end
        checks++;
        if ({info, pause_req, busy} !== {8'd25, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_state got info=%0d pause=%0b busy=%0b, required 25 0 0",
                     info, pause_req, busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        q_start.push_back('{load: 1'b0, addr: 25'h0C00000});
        q_info.push_back(8'd19);
        q_start.push_back('{load: 1'b1, addr: 25'h0C00000});
        q_info.push_back(8'd23);
        request(1'b1, 1'b0, 2'd3);
        pause_ack = 1'b1;
        wait_start("b2b");
        tick();
        request(1'b1, 1'b0, 2'd0);
        request(1'b0, 1'b1, 2'd3);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
`ifdef SS_SLOT_VALID_EN
        m_valid[3] = 1'b1;
`endif
        checks++;
        if ({pause_req, busy} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_release got pause=%0b busy=%0b, required 0 1", pause_req, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hold_release got busy=%0b, required 1", busy);
        end
        pause_ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%0b, required 0", busy);
        end
        tick();
        checks++;
        if (pause_req !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pending_taken got pause=%0b, required 1", pause_req);
        end
        serve(1'b1, 2'd3, 1, 3, 1'b0);
        repeat (3) tick();
        checks++;
        if ({busy, slot_valid} !== {1'b0, m_valid}) begin
            failures++;
            $display("FAIL b2b_final got busy=%0b valid=%b, required 0 %b", busy, slot_valid, m_valid);
        end
    endtask

    task automatic test_same_cycle();
        q_start.push_back('{load: 1'b0, addr: 25'h0400000});
        q_info.push_back(8'd17);
        request(1'b1, 1'b1, 2'd1);
        checks++;
        if (pause_req !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_pause got %0b, required 1", pause_req);
        end
        serve(1'b0, 2'd1, 2, 2, 1'b0);
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_load_dropped got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        q_start.push_back('{load: 1'b0, addr: 25'h0000000});
        request(1'b1, 1'b0, 2'd0);
        pause_ack = 1'b1;
        wait_start("rst");
        tick();
        request(1'b0, 1'b1, 2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pause_req, busy, info_req, info, ss_addr, slot_valid} !==
            {1'b0, 1'b0, 1'b0, 8'd0, AW'(0), VALID_RST}) begin
            failures++;
            $display("FAIL reset_mid_run got pause=%0b busy=%0b req=%0b info=%0d addr=%h valid=%b, required 0 0 0 0 0 %b",
                     pause_req, busy, info_req, info, ss_addr, slot_valid, VALID_RST);
        end
        pause_ack = 1'b0;
        m_valid = VALID_RST;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if ({busy, pause_req} !== 2'b00) begin
            failures++;
            $display("FAIL reset_pending_dropped got busy=%0b pause=%0b, required 0 0", busy, pause_req);
        end
    endtask

    task automatic test_invalidate();
        q_start.push_back('{load: 1'b0, addr: 25'h0800000});
        q_info.push_back(8'd18);
        q_start.push_back('{load: 1'b0, addr: 25'h0400000});
        q_info.push_back(8'd17);
        request(1'b1, 1'b0, 2'd2);
        serve(1'b0, 2'd2, 1, 2, 1'b0);
        request(1'b1, 1'b0, 2'd1);
        serve(1'b0, 2'd1, 1, 2, 1'b1);
        checks++;
        if (slot_valid !== m_valid) begin
            failures++;
            $display("FAIL invalidate_wins got %b, required %b", slot_valid, m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_empty_load();
        test_save_basic();
        test_timeout();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid_run();
        test_invalidate();
        repeat (2) tick();
        checks++;
        if (q_start.size() != 0 || q_info.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d starts %0d infos outstanding, required 0 0",
                     q_start.size(), q_info.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion by time limit, required finish");
        $fatal(1, "watchdog");
    end

endmodule
